// File: rtl/spi_subunit.sv
// spi_subunit - SPI mode-0 subunit (peripheral) oversampled in the system clock domain.
//
// SCLK, MOSI and CS are brought through SYNC_STAGES flops; SCLK and CS get one
// extra history flop so that their edges become single-cycle strobes. Received
// bytes are presented on rx_data with a one-cycle rx_valid pulse. Bytes to send
// are accepted through a one-entry ready/valid holding register.
//
// Build option: define SPI_SUBUNIT_FRAME_ERR_EN to enable mid-byte CS
// deassertion detection (frame_error). Undefined, frame_error is tied 0.
//
// Parameters:
//   SYNC_STAGES    synchronizer depth on SPI_SCLK/SPI_MOSI/SPI_CS (>= 2)
//   CLK_FREQUENCY  system clock in Hz (informational)
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   SPI_SCLK       serial clock from controller, idle low
//   SPI_MOSI       controller-to-subunit data, MSB first
//   SPI_CS         chip select, active low
//   SPI_MISO       subunit-to-controller data, MSB first
//   tx_data/tx_valid/tx_ready  next byte to transmit (holding register)
//   rx_data/rx_valid           last received byte, one-cycle valid pulse
//   busy           synchronized CS is low
//   tx_underrun    one-cycle pulse, byte load found nothing to send
//   frame_error    one-cycle pulse, CS rose mid-byte
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | CS high, MISO held 0, SCLK edges ignored
// ST_LOAD   | one cycle after CS fall: load tx_shift, clear bit_cnt
// ST_ACTIVE | shifting; CS rise returns to ST_IDLE from any point

module spi_subunit #(
    parameter int SYNC_STAGES   = 2,
    parameter int CLK_FREQUENCY = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SPI_SCLK,
    input  logic       SPI_MOSI,
    input  logic       SPI_CS,
    output logic       SPI_MISO,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       tx_underrun,
    output logic       frame_error
);

    generate
        if (SYNC_STAGES < 2 || CLK_FREQUENCY < 1) begin : g_param_check
            $error("spi_subunit: SYNC_STAGES must be >= 2 and CLK_FREQUENCY positive");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_hist;
    logic                   cs_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_hist <= 1'b0;
            cs_hist   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            cs_hist   <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign sclk_fall = ~sclk_s & sclk_hist;
    assign cs_fall   = ~cs_s & cs_hist;
    assign cs_rise   = cs_s & ~cs_hist;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [6:0] rx_shift;
    logic [7:0] hold_data;
    logic       hold_full;
    logic       load_now;

`ifdef SPI_SUBUNIT_FRAME_ERR_EN
    logic frame_err_r;
    assign frame_error = frame_err_r;
`else
    assign frame_error = 1'b0;
`endif

    // A byte load happens in LOAD and on the SCLK fall that closes a byte.
    // CS rise takes priority over any SCLK edge seen in the same cycle.
    always_comb begin
        load_now = 1'b0;
        case (state)
            ST_LOAD:   load_now = 1'b1;
            ST_ACTIVE: load_now = ~cs_rise & sclk_fall & (bit_cnt == 3'd0);
            default:   load_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            tx_shift    <= 8'h00;
            rx_shift    <= 7'h00;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            hold_data   <= 8'h00;
            hold_full   <= 1'b0;
`ifdef SPI_SUBUNIT_FRAME_ERR_EN
            frame_err_r <= 1'b0;
`endif
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
`ifdef SPI_SUBUNIT_FRAME_ERR_EN
            frame_err_r <= 1'b0;
`endif
            // An empty register with tx_valid high at load time hands the
            // byte straight to tx_shift instead of capturing it.
            if (load_now) begin
                if (hold_full) begin
                    tx_shift  <= hold_data;
                    hold_full <= 1'b0;
                end else if (tx_valid) begin
                    tx_shift <= tx_data;
                end else begin
                    tx_shift    <= 8'h00;
                    tx_underrun <= 1'b1;
                end
            end else if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    bit_cnt <= 3'd0;
                    state   <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
`ifdef SPI_SUBUNIT_FRAME_ERR_EN
                        if (bit_cnt != 3'd0) begin
                            frame_err_r <= 1'b1;
                        end
`endif
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[5:0], mosi_s};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= {rx_shift, mosi_s};
                            rx_valid <= 1'b1;
                        end
                    end else if (sclk_fall && bit_cnt != 3'd0) begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign SPI_MISO = (state != ST_IDLE) & tx_shift[7];
    assign tx_ready = ~hold_full;
    assign busy     = ~cs_s;

endmodule

// File: tb/tb_spi_subunit.sv
module tb_spi_subunit;
    localparam int SYNC_STAGES   = 2;
    localparam int CLK_FREQUENCY = 100_000_000;
    localparam int SETUP         = SYNC_STAGES + 4;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_cs   = 1'b1;
    logic       spi_miso;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       tx_underrun;
    logic       frame_error;

    int errors  = 0;
    int checks  = 0;
    int rx_cnt  = 0;
    int uru_cnt = 0;
    int fe_cnt  = 0;

    spi_subunit #(
        .SYNC_STAGES  (SYNC_STAGES),
        .CLK_FREQUENCY(CLK_FREQUENCY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SPI_SCLK   (spi_sclk),
        .SPI_MOSI   (spi_mosi),
        .SPI_CS     (spi_cs),
        .SPI_MISO   (spi_miso),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .tx_underrun(tx_underrun),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid)    rx_cnt  = rx_cnt + 1;
            if (tx_underrun) uru_cnt = uru_cnt + 1;
            if (frame_error) fe_cnt  = fe_cnt + 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Controller side: mode 0, MOSI set while SCLK low, MISO sampled at rise.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input int half,
                            output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[7-i];
            repeat (half) @(negedge clk);
            mi = {mi[6:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (half) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_start(input int setup);
        spi_cs = 1'b0;
        repeat (setup) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (2) @(negedge clk);
        spi_cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_wait: tx_ready=%b required 1 within 100 clk", tx_ready);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] mi;
        cs_start(SETUP);
        spi_bits(8'hC3, 8, 5, mi);
        repeat (6) @(negedge clk);
        checks++;
        if (rx_data !== 8'hC3) begin
            errors++; $display("FAIL pre_reset_rx: rx_data=%h required c3", rx_data);
        end
        push(8'h44);
        spi_bits(8'h00, 3, 5, mi);
        rst_n = 1'b0;
        #1;
        checks++;
        if (spi_miso !== 1'b0) begin errors++; $display("FAIL rst_miso: got %b required 0", spi_miso); end
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b required 1", tx_ready); end
        checks++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h required 00", rx_data); end
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b required 0", rx_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++;
        if (tx_underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b required 0", tx_underrun); end
        checks++;
        if (frame_error !== 1'b0) begin errors++; $display("FAIL rst_frame_error: got %b required 0", frame_error); end
        spi_cs   = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b required 0", busy); end
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL post_rst_tx_ready: got %b required 1", tx_ready); end
        checks++;
        if (spi_miso !== 1'b0) begin errors++; $display("FAIL post_rst_miso: got %b required 0", spi_miso); end
    endtask

    task automatic test_single_byte();
        logic [7:0] mi;
        int r0;
        r0 = rx_cnt;
        push(8'hA5);
        checks++;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL single_full: tx_ready=%b required 0", tx_ready); end
        cs_start(SETUP);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: busy=%b required 1", busy); end
        spi_bits(8'h3C, 8, 100, mi);
        cs_end();
        checks++;
        if (rx_data !== 8'h3C) begin errors++; $display("FAIL single_rx: rx_data=%h required 3c", rx_data); end
        checks++;
        if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL single_rx_pulses: got %0d required 1", rx_cnt - r0); end
        checks++;
        if (mi !== 8'hA5) begin errors++; $display("FAIL single_miso: got %h required a5", mi); end
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL single_ready: tx_ready=%b required 1", tx_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m1, m2;
        int r0, u0;
        r0 = rx_cnt;
        u0 = uru_cnt;
        push(8'h80);
        cs_start(SETUP);
        push(8'h7F);
        spi_bits(8'h01, 8, 100, m1);
        checks++;
        if (rx_data !== 8'h01) begin errors++; $display("FAIL b2b_rx1: rx_data=%h required 01", rx_data); end
        push(8'h11);
        spi_bits(8'h02, 8, 100, m2);
        cs_end();
        checks++;
        if (rx_data !== 8'h02) begin errors++; $display("FAIL b2b_rx2: rx_data=%h required 02", rx_data); end
        checks++;
        if (rx_cnt - r0 !== 2) begin errors++; $display("FAIL b2b_rx_pulses: got %0d required 2", rx_cnt - r0); end
        checks++;
        if (m1 !== 8'h80) begin errors++; $display("FAIL b2b_miso1: got %h required 80", m1); end
        checks++;
        if (m2 !== 8'h7F) begin errors++; $display("FAIL b2b_miso2: got %h required 7f", m2); end
        checks++;
        if (uru_cnt - u0 !== 0) begin errors++; $display("FAIL b2b_underrun: got %0d pulses required 0", uru_cnt - u0); end
    endtask

    task automatic test_underrun();
        logic [7:0] mi;
        int u0;
        u0 = uru_cnt;
        cs_start(SETUP);
        checks++;
        if (uru_cnt - u0 !== 1) begin errors++; $display("FAIL underrun_load: got %0d pulses required 1", uru_cnt - u0); end
        spi_bits(8'hFF, 8, 100, mi);
        cs_end();
        checks++;
        if (mi !== 8'h00) begin errors++; $display("FAIL underrun_miso: got %h required 00", mi); end
        checks++;
        if (rx_data !== 8'hFF) begin errors++; $display("FAIL underrun_rx: rx_data=%h required ff", rx_data); end
    endtask

    task automatic test_frame_error();
        logic [7:0] mi;
        int r0, f0, fe_exp;
`ifdef SPI_SUBUNIT_FRAME_ERR_EN
        fe_exp = 1;
`else
        fe_exp = 0;
`endif
        r0 = rx_cnt;
        f0 = fe_cnt;
        cs_start(SETUP);
        spi_bits(8'hE7, 5, 20, mi);
        cs_end();
        checks++;
        if (rx_cnt - r0 !== 0) begin errors++; $display("FAIL fe_rx_pulses: got %0d required 0", rx_cnt - r0); end
        checks++;
        if (fe_cnt - f0 !== fe_exp) begin errors++; $display("FAIL fe_pulses: got %0d required %0d", fe_cnt - f0, fe_exp); end
        checks++;
        if (rx_data !== 8'hFF) begin errors++; $display("FAIL fe_rx_hold: rx_data=%h required ff", rx_data); end
        cs_start(SETUP);
        spi_bits(8'h5A, 8, 20, mi);
        cs_end();
        checks++;
        if (rx_data !== 8'h5A) begin errors++; $display("FAIL fe_next_rx: rx_data=%h required 5a", rx_data); end
        checks++;
        if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL fe_next_pulses: got %0d required 1", rx_cnt - r0); end
    endtask

    task automatic test_min_timing();
        logic [7:0] mi;
        int r0;
        r0 = rx_cnt;
        push(8'h96);
        // CS fall to first SCLK rise is (SETUP-5) + half(5) = SETUP clk.
        cs_start(SETUP - 5);
        spi_bits(8'h96, 8, 5, mi);
        cs_end();
        checks++;
        if (mi !== 8'h96) begin errors++; $display("FAIL min_miso: got %h required 96", mi); end
        checks++;
        if (rx_data !== 8'h96) begin errors++; $display("FAIL min_rx: rx_data=%h required 96", rx_data); end
        checks++;
        if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL min_rx_pulses: got %0d required 1", rx_cnt - r0); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_underrun();
        test_frame_error();
        test_min_timing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_subunit.md
# spi_subunit

SPI mode-0 subunit (peripheral) end of the team's SPI link. It receives SCLK, MOSI and CS from an SPI controller and returns MISO, all oversampled in the local clock domain. Received bytes go to local logic with a valid pulse. Bytes to transmit are accepted through a one-entry ready/valid holding register. The block sits at the board-facing edge, opposite the SPI controller, and is clocked by the system clock.

## Interface
- SYNC_STAGES, 2, synchronizer flops on SPI_SCLK, SPI_MOSI and SPI_CS (≥2)
- CLK_FREQUENCY, 100_000_000, system clock in Hz; documentation and bench use only
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- SPI_SCLK  in  1  serial clock from controller, idle low
- SPI_MOSI  in  1  controller-to-subunit data, MSB first
- SPI_CS  in  1  chip select, active low
- SPI_MISO  out  1  subunit-to-controller data, MSB first
- tx_data  in  8  next byte to transmit
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  holding register empty; byte accepted when tx_valid && tx_ready
- rx_data  out  8  last complete received byte, held until next byte
- rx_valid  out  1  one-cycle pulse, rx_data updated
- busy  out  1  synchronized CS is low
- tx_underrun  out  1  one-cycle pulse, byte load found holding register empty
- frame_error  out  1  one-cycle pulse, CS deasserted mid-byte (see Configuration)

## Operation
- SCLK/MOSI/CS pass through SYNC_STAGES flops, plus one history flop for edge detection. SCLK rise/fall and CS fall/rise are single-cycle strobes.
- FSM states:
  - IDLE: synchronized CS high; SPI_MISO driven 0. CS fall → LOAD.
  - LOAD: one cycle. Loads tx_shift, clears bit_cnt, → ACTIVE.
  - ACTIVE: shifts bits. CS rise → IDLE from any point.
- Byte load: tx_shift ← holding register if full, and the register is marked empty.
  - If the register is empty and tx_valid is high that cycle, tx_data bypasses directly, with no underrun.
  - Otherwise tx_shift ← 0x00 and tx_underrun pulses.
- SPI_MISO = tx_shift[7] while in ACTIVE or LOAD.
- SCLK rise, sampling:
  - rx_shift ← {rx_shift[6:0], MOSI}; bit_cnt increments and wraps 7→0.
  - On bit 7: rx_data ← {rx_shift[6:0], MOSI} and rx_valid pulses.
- SCLK fall, shifting:
  - If bit_cnt == 0 (byte boundary, CS still low): byte load as above, so multi-byte transfers continue seamlessly.
  - Else tx_shift ← {tx_shift[6:0], 0}.
- Holding register: tx_ready = ~full. Load and capture in the same cycle: the load takes the old contents, and the captured byte is not possible because ready is low while full.
- CS rise with bit_cnt ≠ 0: partial byte discarded, no rx_valid, frame_error pulse (if enabled). CS rise with bit_cnt == 0: clean end of transfer. Holding register contents are kept across transfers.
- Edges of SCLK while in IDLE are ignored.

## Timing
- Reset values: SPI_MISO 0, tx_ready 1, rx_data 0x00, rx_valid 0, busy 0, tx_underrun 0, frame_error 0. Synchronizers reset to CS=1, SCLK=0, MOSI=0, FSM to IDLE, holding register empty.
- Latency from a pin edge to its internal strobe: SYNC_STAGES+1 clk.
  - rx_valid: asserted SYNC_STAGES+2 clk after the 8th SCLK rise.
  - MISO update: SYNC_STAGES+2 clk after SCLK fall.
- Controller constraints:
  - SCLK high and low times ≥ SYNC_STAGES+3 clk each, i.e. SCLK ≤ CLK/10 with defaults.
  - CS fall to first SCLK rise ≥ SYNC_STAGES+4 clk.
  - Last SCLK fall to CS rise ≥ 2 clk.
- Reset mid-transfer: all state cleared immediately. The block ignores the remainder of the transfer until the next CS fall.
- Simultaneous CS rise and SCLK edge in the same cycle: CS rise wins and the SCLK edge is dropped.

## Configuration
- SPI_SUBUNIT_FRAME_ERR_EN defined: mid-byte CS deassertion detection is present and frame_error pulses as above.
- Not defined: detection logic is omitted and frame_error is tied 0. Partial bytes are still discarded silently.

## Test plan
- Reset: assert rst_n=0 mid-activity, release → all outputs at reset values; tx_ready=1, SPI_MISO=0.
- Single byte at SCLK=CLK/200: preload tx 0xA5; controller sends 0x3C → rx_data=0x3C with exactly one rx_valid pulse; controller reads 0xA5; tx_ready returns 1.
- Two bytes with CS held low: preload 0x80, load 0x7F during the first byte; controller sends 0x01,0x02 → rx_valid twice (0x01, 0x02); MISO returns 0x80, 0x7F; no underrun.
- Underrun: nothing loaded; controller sends 0xFF → MISO reads 0x00, one tx_underrun pulse at LOAD, rx_data=0xFF.
- Frame error: CS raised after 5 SCLKs → no rx_valid; frame_error pulses once with macro defined, stays 0 without it. Next full transfer of 0x5A is received correctly.
- Minimum timing: SCLK=CLK/10 and CS setup of exactly SYNC_STAGES+4 clk, with bytes 0x96 each way → exchanged without error.
